fan_angle_tick_gen: RTL and testbench



---
 rtl/fan_pkg.sv | 16 +
 rtl/hall_sync_edge.sv | 36 +++
 rtl/fan_angle_tick_gen.sv | 136 +++++++++++++
 tb/tb_fan_angle_tick_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// fan_pkg: shared definitions for the fan angle-step generator.
//   STEPS_DEF - default number of angle steps per revolution
//   ANGLE_W   - width of the angle output (enough for 0..359)
//   state_t   - lock state of the generator
package fan_pkg;

  localparam int STEPS_DEF = 360;
  localparam int ANGLE_W   = 9;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    RUN
  } state_t;

endpackage

// File: rtl/hall_sync_edge.sv
// hall_sync_edge: brings the asynchronous hall sensor into the clk domain
// and turns each rising edge into a single-cycle pulse.
//   clk      - system clock
//   rst      - asynchronous, active-high reset
//   async_in - raw hall sensor pin
//   edge_out - registered one-cycle pulse per synchronized rising edge
// edge_out goes high on the third clock edge that sees async_in high.
module hall_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_out
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a true shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync2_d  <= 1'b0;
      edge_out <= 1'b0;
    end else begin
      sync1    <= async_in;
      sync2    <= sync1;
      sync2_d  <= sync2;
      // Only the second stage is used downstream; sync1 may be metastable.
      edge_out <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/fan_angle_tick_gen.sv
// fan_angle_tick_gen: measures the revolution period from a once-per-turn
// hall sensor and emits STEPS evenly spaced one-cycle fanclk pulses per turn.
//   clk    - system clock
//   rst    - asynchronous, active-high reset
//   hall   - raw hall sensor, one rising edge per revolution
//   fanclk - one-cycle angle-step pulse
//   index  - one-cycle pulse on each accepted hall edge (with fanclk)
//   angle  - current angle step, 0 at index
//   locked - high while the generator is running
//   period - last measured revolution period in clk cycles
module fan_angle_tick_gen
  import fan_pkg::*;
#(
  parameter int CNT_W      = 24,
  parameter int STEPS      = STEPS_DEF,
  parameter int MIN_PERIOD = 1000,
  parameter int MAX_PERIOD = 2**24 - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hall,
  output logic               fanclk,
  output logic               index,
  output logic [ANGLE_W-1:0] angle,
  output logic               locked,
  output logic [CNT_W-1:0]   period
);

  localparam logic [CNT_W-1:0]   MAX_CNT    = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W:0]     MIN_CNT    = (CNT_W+1)'(MIN_PERIOD);
  localparam logic [CNT_W:0]     STEP_INC   = (CNT_W+1)'(STEPS);
  localparam logic [ANGLE_W-1:0] LAST_ANGLE = ANGLE_W'(STEPS - 1);

  logic             hall_edge;
  state_t           state;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] acc;

  logic [CNT_W:0]   meas;
  logic [CNT_W:0]   sum;
  logic             timeout;
  logic             restart;
  logic             step;
  logic [CNT_W-1:0] per_cnt_inc;
  logic [CNT_W-1:0] acc_hold;

  hall_sync_edge u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (hall),
    .edge_out (hall_edge)
  );

  // NOTE: every signal assigned here is assigned on every pass through the
  // block, so no latch can be inferred.
  always_comb begin
    meas        = {1'b0, per_cnt} + (CNT_W+1)'(1);
    sum         = {1'b0, acc} + STEP_INC;
    // Timeout takes priority over an edge in the same cycle, which also keeps
    // meas within CNT_W bits whenever it is captured into period.
    timeout     = (state != IDLE) && (per_cnt == MAX_CNT);
    restart     = (state != IDLE) && !timeout && hall_edge && (meas >= MIN_CNT);
    step        = (sum >= {1'b0, period}) && (angle < LAST_ANGLE);
    per_cnt_inc = (per_cnt == MAX_CNT) ? per_cnt : per_cnt + CNT_W'(1);
    // Once the last angle is reached the phase accumulator parks at period.
    acc_hold    = (sum > {1'b0, period}) ? period : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      per_cnt <= '0;
      acc     <= '0;
      fanclk  <= 1'b0;
      index   <= 1'b0;
      angle   <= '0;
      locked  <= 1'b0;
      period  <= '0;
    end else begin
      fanclk <= 1'b0;
      index  <= 1'b0;
      if (restart) begin
        // Accepted edge: new period, restart the angle; wins over a DDS step.
        state   <= RUN;
        per_cnt <= '0;
        period  <= meas[CNT_W-1:0];
        acc     <= '0;
        angle   <= '0;
        fanclk  <= 1'b1;
        index   <= 1'b1;
        locked  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (hall_edge) begin
              state   <= ACQUIRE;
              per_cnt <= '0;
            end else begin
              per_cnt <= per_cnt_inc;
            end
          end
          ACQUIRE: begin
            if (timeout) begin
              state   <= IDLE;
              per_cnt <= '0;
            end else begin
              per_cnt <= per_cnt_inc;
            end
          end
          RUN: begin
            if (timeout) begin
              // Stall: drop lock, keep the last period for observation.
              state   <= IDLE;
              per_cnt <= '0;
              acc     <= '0;
              angle   <= '0;
              locked  <= 1'b0;
            end else begin
              per_cnt <= per_cnt_inc;
              if (step) begin
                // Modular subtraction is exact: the true result is < STEPS.
                acc    <= sum[CNT_W-1:0] - period;
                angle  <= angle + ANGLE_W'(1);
                fanclk <= 1'b1;
              end else begin
                acc <= acc_hold;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fan_angle_tick_gen.sv
// tb_fan_angle_tick_gen: scoreboard bench for fan_angle_tick_gen.
// Hall edges are planned as absolute cycle numbers; a reference model turns
// that plan into the expected fanclk/index events and lock transitions, and
// a monitor pops and compares them as the DUT produces them.
module tb_fan_angle_tick_gen;
  import fan_pkg::*;

  localparam int CNT_W  = 24;
  localparam int STEPS  = 360;
  localparam int MIN_P  = 400;
  localparam int MAX_P  = 10000;
  localparam int LAT    = 4;   // hall driven at negedge N -> outputs after posedge N+4
  localparam int HALL_W = 10;  // hall high time in cycles

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               hall = 1'b0;
  logic               fanclk;
  logic               index;
  logic [ANGLE_W-1:0] angle;
  logic               locked;
  logic [CNT_W-1:0]   period;

  fan_angle_tick_gen #(
    .CNT_W      (CNT_W),
    .STEPS      (STEPS),
    .MIN_PERIOD (MIN_P),
    .MAX_PERIOD (MAX_P)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .hall   (hall),
    .fanclk (fanclk),
    .index  (index),
    .angle  (angle),
    .locked (locked),
    .period (period)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int ang;
    int idx;
    int per;
  } fc_ev_t;

  typedef struct {
    int cyc;
    int val;
    int ang;
    int per;
  } lk_ev_t;

  fc_ev_t fc_q[$];
  lk_ev_t lk_q[$];
  int     rise_q[$];
  fc_ev_t mev;
  lk_ev_t lev;
  logic   prev_locked = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  // Pulses of one revolution starting at cycle e with period p: step n lands
  // on the first cycle k after e where k*STEPS >= n*p. Stops before bound.
  task automatic emit_rev(input int e, input int p, input int bound);
    for (int n = 1; n < STEPS; n++) begin
      int k;
      k = (n * p + STEPS - 1) / STEPS;
      if (e + k >= bound) break;
      fc_q.push_back('{e + k, n, 0, p});
    end
  endtask

  // Reference model over the planned hall rises (mode 0 idle, 1 acquire, 2 run).
  // reset_at >= 0: rst is asserted just after the negedge of that cycle.
  task automatic model(input int reset_at);
    int mode, last, rev_e, rev_p, c, t;
    mode = 0; last = 0; rev_e = 0; rev_p = 0; t = -1;
    foreach (rise_q[i]) begin
      c = rise_q[i] + LAT;
      if (reset_at >= 0 && c > reset_at) break;
      if (mode != 0 && c >= last + MAX_P + 1) begin
        t = last + MAX_P + 1;
        if (mode == 2) begin
          emit_rev(rev_e, rev_p, t);
          lk_q.push_back('{t, 0, 0, rev_p});
        end
        mode = 0;
        if (c == t) continue;  // the edge is swallowed by the timeout
      end
      if (mode == 0) begin
        mode = 1;
        last = c;
      end else if (c - last >= MIN_P) begin
        if (mode == 2) emit_rev(rev_e, rev_p, c);
        else lk_q.push_back('{c, 1, 0, c - last});
        rev_e = c;
        rev_p = c - last;
        fc_q.push_back('{c, 0, 1, rev_p});
        mode = 2;
        last = c;
      end
    end
    if (mode == 2) begin
      t = (reset_at >= 0) ? reset_at + 1 : last + MAX_P + 1;
      emit_rev(rev_e, rev_p, t);
      lk_q.push_back('{t, 0, 0, (reset_at >= 0) ? 0 : rev_p});
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drive_rises();
    foreach (rise_q[i]) begin
      wait_cyc(rise_q[i]);
      hall = 1'b1;
      wait_cyc(rise_q[i] + HALL_W);
      hall = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_fanclk"}, fanclk, 0);
    check({tag, "_index"},  index,  0);
    check({tag, "_angle"},  angle,  0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_period"}, period, 0);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_fanclk_pending"}, fc_q.size(), 0);
    check({tag, "_lock_pending"},   lk_q.size(), 0);
  endtask

  // Monitor: compares every fanclk pulse and every locked transition.
  always @(negedge clk) begin
    if (fanclk === 1'b1) begin
      if (fc_q.size() == 0) begin
        check("fanclk_unexpected", 1, 0);
      end else begin
        mev = fc_q.pop_front();
        check("fanclk_cycle", cyc, mev.cyc);
        check("fanclk_angle", angle, mev.ang);
        check("fanclk_index", index, mev.idx);
        check("fanclk_period", period, mev.per);
        check("fanclk_locked", locked, 1);
      end
    end else if (index === 1'b1) begin
      check("index_without_fanclk", 1, 0);
    end
    if (locked !== prev_locked) begin
      if (lk_q.size() == 0) begin
        check("locked_unexpected", locked, prev_locked);
      end else begin
        lev = lk_q.pop_front();
        check("locked_cycle", cyc, lev.cyc);
        check("locked_value", locked, lev.val);
        check("locked_angle", angle, lev.ang);
        check("locked_period", period, lev.per);
      end
    end
    prev_locked = locked;
  end

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog at cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int r;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Phase A: lock, steady, non-integer spacing, bounce, speed changes,
    // random periods, then a stall timeout.
    n = cyc + 20;
    rise_q.push_back(n);
    repeat (4) begin n += 3600; rise_q.push_back(n); end
    repeat (2) begin n += 3700; rise_q.push_back(n); end
    n += 3600; rise_q.push_back(n);
    rise_q.push_back(n + 50);               // bounce shortly after an edge
    n += 3600; rise_q.push_back(n);
    n += 3000; rise_q.push_back(n);         // speeding up
    n += 4000; rise_q.push_back(n);         // slowing down
    repeat (3) begin
      n += $urandom_range(1500, 3500);
      rise_q.push_back(n);
      if ($urandom_range(0, 1) == 1) rise_q.push_back(n + $urandom_range(30, 300));
    end
    model(-1);
    drive_rises();
    wait_cyc(n + LAT + MAX_P + 20);
    check_drained("phase_a");

    // Phase B: reset while running.
    rise_q.delete();
    n = cyc + 20;
    rise_q.push_back(n);
    n += 3600; rise_q.push_back(n);
    r = n + LAT + 1800;
    model(r);
    drive_rises();
    wait_cyc(r);
    #2 rst = 1'b1;
    #1 check_outputs_zero("mid_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_drained("phase_b_reset");

    // Phase C: relock after reset needs two edges, then stall again.
    rise_q.delete();
    n = cyc + 20;
    rise_q.push_back(n);
    n += 3600; rise_q.push_back(n);
    n += 3600; rise_q.push_back(n);
    model(-1);
    drive_rises();
    wait_cyc(n + LAT + MAX_P + 20);
    check_drained("phase_c");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
